serial_word_receiver: RTL and testbench
=======================================

// Module: serial_word_receiver
// PURPOSE
//   Upstream stage of the data-number counter. Samples a 1-bit serial line on
//   slow-clock enables, detects a start bit, and shifts in WORD_W data bits MSB-first.
//   It presents the assembled word and a word-complete strobe (cnt2), which feeds
//   the counter's cnt2 input. Once the counter reports all words received (co2),
//   the receiver halts until reset.
// PARAMETERS
//   WORD_W   8   data bits per word; legal range is 2 or more
// PORTS
//   clk       in   1        system clock; all state changes on the posedge
//   rst       in   1        asynchronous, active-high reset
//   clkEn     in   1        bit-rate enable; FSM and datapath advance only when it is 1
//   serIn     in   1        serial data line; idle high, start bit low
//   co2In     in   1        all-words-done flag from the downstream counter (sticky)
//   cnt2      out  1        word-complete strobe to the downstream counter
//   dataOut   out  WORD_W   last fully received word
//   busy      out  1        1 while a word is being shifted in
// BEHAVIOUR
//   Reset (async, any time, including mid-word): state=IDLE, bitCnt=0, shReg=0,
//     dataOut=0, cnt2=0, busy=0. Reset overrides clkEn.
//   Gating: every transition and register update below occurs only on posedge clk
//     with clkEn=1. When clkEn=0, all state holds.
//   States: IDLE, SHIFT, DONE, HALT (2-bit encoding).
//   IDLE : co2In=1 -> HALT; else serIn=0 (start bit) -> SHIFT with bitCnt<=0;
//          else remain in IDLE.
//   SHIFT: shReg<={shReg[WORD_W-2:0],serIn}; bitCnt<=bitCnt+1.
//          When bitCnt==WORD_W-1: dataOut<={shReg[WORD_W-2:0],serIn}, go to DONE.
//          co2In is ignored in SHIFT; a started word always completes.
//   DONE : cnt2=1 (decoded from state, no extra register).
//          Next enabled edge: co2In=1 -> HALT, else -> IDLE.
//          The serIn value at this edge is the stop bit and is ignored.
//   HALT : sticky until rst; cnt2=0, busy=0, dataOut holds its value.
//   cnt2 is high for exactly one clkEn period. The downstream counter therefore
//     sees exactly one edge with (clkEn && cnt2) per word.
//   busy = (state==SHIFT).
//   Latency: counting the start-bit sample edge as edge 1, data bits are sampled
//     on edges 2..WORD_W+1. DONE is entered and dataOut is updated on edge WORD_W+1.
//     The FSM returns to IDLE on edge WORD_W+2.
//   The earliest next start bit is sampled on edge WORD_W+3, so at least one
//     idle-high bit separates words.
//   dataOut changes only on DONE entry; it is stable throughout DONE and until
//     the next word completes.
//   bitCnt width is $clog2(WORD_W) and wraps by design: reset to 0 on entering SHIFT.
//   co2In asserted in DONE: cnt2 stays high for that period, then the FSM moves to HALT.
// STRUCTURE
//   Shared include file (serial_rx_defs.vh): state encodings S_IDLE=2'd0,
//     S_SHIFT=2'd1, S_DONE=2'd2, S_HALT=2'd3, and the default WORD_W.
//   One sub-module, sipo_shift_reg #(WORD_W): shift-in-LSB register with a shift
//     enable; clk/rst as above. The FSM, bitCnt and dataOut capture stay in this module.
// TESTING  (WORD_W=8, clkEn one-in-4 clk pulses unless noted)
//   1. Reset, serIn=1 for 20 enables -> state IDLE, cnt2=0, busy=0, dataOut=8'h00.
//   2. Start 0 then bits of 8'hA5 MSB-first, then stop 1 -> dataOut=8'hA5 on edge 9;
//      cnt2 high exactly one clkEn period; exactly one clkEn&&cnt2 edge.
//   3. Four back-to-back words 8'h01,8'h80,8'hFF,8'h00 with one stop bit each ->
//      four cnt2 pulses, dataOut matches each word in turn; downstream model co2 rises.
//   4. co2In raised mid-SHIFT of word 8'h3C -> word completes, dataOut=8'h3C,
//      cnt2 pulse, then HALT; a further start bit yields no busy and no cnt2.
//   5. rst asserted after 4 data bits of 8'hF0 -> immediate IDLE, dataOut=0,
//      busy=0; a following 8'h5A is received correctly.
//   6. clkEn held 0 for 50 clks mid-word, serIn toggling -> no state or data change;
//      the word completes correctly once clkEn resumes.

Source files
------------

// File: rtl/serial_word_receiver_pkg.sv
// Shared definitions for the serial word receiver: FSM state encoding and
// the default word width.
package serial_word_receiver_pkg;

  localparam int WORD_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_word_receiver_sipo.sv
// Serial-in parallel-out shift register: new bit enters at the LSB, so a
// word sent MSB-first ends up in natural bit order.
module sipo_shift_reg #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              din,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WORD_W-2:0], din};
    end
  end

endmodule

// File: rtl/serial_word_receiver.sv
// Serial word receiver: detects a low start bit on bit-rate enables, shifts
// in WORD_W bits MSB-first and strobes cnt2 once per word until co2In halts it.
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              serIn,
  input  logic              co2In,
  output logic              cnt2,
  output logic [WORD_W-1:0] dataOut,
  output logic              busy
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] sh_reg;
  logic              shift_en;
  logic              last_bit;
  logic              start_seen;

  assign shift_en   = clkEn && (state == S_SHIFT);
  assign last_bit   = (bit_cnt == LAST_BIT);
  assign start_seen = (state == S_IDLE) && !co2In && !serIn;

  sipo_shift_reg #(.WORD_W(WORD_W)) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .din      (serIn),
    .q        (sh_reg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (clkEn) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (co2In)       state_next = S_HALT;
        else if (!serIn) state_next = S_SHIFT;
      end
      // co2In is deliberately ignored here so a started word always completes
      S_SHIFT: begin
        if (last_bit) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = co2In ? S_HALT : S_IDLE;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // bit counter wraps naturally; it is re-zeroed on every start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (clkEn) begin
      if (start_seen) begin
        bit_cnt <= '0;
      end else if (state == S_SHIFT) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  // capture the word including the bit being sampled on this final edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataOut <= '0;
    end else if (shift_en && last_bit) begin
      dataOut <= {sh_reg[WORD_W-2:0], serIn};
    end
  end

  assign cnt2 = (state == S_DONE);
  assign busy = (state == S_SHIFT);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver: frame-level reference model
// with directed and randomized words, reset, halt and enable-stall cases.
module tb_serial_word_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clkEn = 1'b0;
  logic       serIn = 1'b1;
  logic       co2In = 1'b0;
  logic       cnt2;
  logic [7:0] dataOut;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int pulses = 0;      // edges with clkEn && cnt2 seen by the downstream counter
  int high_clks = 0;   // clocks with cnt2 high
  logic [7:0] exp_data = 8'h00;
  localparam int CO2_TARGET = 4;

  serial_word_receiver #(.WORD_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .clkEn   (clkEn),
    .serIn   (serIn),
    .co2In   (co2In),
    .cnt2    (cnt2),
    .dataOut (dataOut),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One bit-rate period: four clocks, the last one enabled.
  task automatic en_cycle(input logic s);
    @(negedge clk);
    serIn = s;
    clkEn = 1'b0;
    if (cnt2) high_clks++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cnt2) high_clks++;
    end
    clkEn = 1'b1;
    if (cnt2) pulses++;
    @(posedge clk);
    #1;
    clkEn = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    co2In = 1'b0;
    serIn = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    exp_data = 8'h00;
    pulses = 0;
  endtask

  task automatic stall(input string tag);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      clkEn = 1'b0;
      serIn = ~serIn;
      if (k % 10 == 9) begin
        check({tag, "_stall_busy"}, 32'(busy), 32'd1);
        check({tag, "_stall_data"}, 32'(dataOut), 32'(exp_data));
        check({tag, "_stall_cnt2"}, 32'(cnt2), 32'd0);
      end
    end
  endtask

  // co2_at / stall_at name a data-bit index (7 = MSB); -1 disables.
  task automatic send_word(input string tag, input logic [7:0] w,
                           input int co2_at, input int stall_at);
    int p0;
    p0 = pulses;
    en_cycle(1'b0);
    check({tag, "_start_busy"}, 32'(busy), 32'd1);
    for (int i = 7; i >= 0; i--) begin
      if (stall_at == i) stall(tag);
      en_cycle(w[i]);
      if (i > 0) begin
        check({tag, "_shift_busy"}, 32'(busy), 32'd1);
        check({tag, "_shift_data"}, 32'(dataOut), 32'(exp_data));
        check({tag, "_shift_cnt2"}, 32'(cnt2), 32'd0);
      end
      if (co2_at == i) co2In = 1'b1;
    end
    exp_data = w;
    check({tag, "_done_data"}, 32'(dataOut), 32'(exp_data));
    check({tag, "_done_cnt2"}, 32'(cnt2), 32'd1);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    high_clks = 0;
    en_cycle(1'b1);
    check({tag, "_stop_cnt2"}, 32'(cnt2), 32'd0);
    check({tag, "_stop_busy"}, 32'(busy), 32'd0);
    check({tag, "_one_pulse"}, 32'(pulses), 32'(p0 + 1));
    check({tag, "_cnt2_clks"}, 32'(high_clks), 32'd4);
    check({tag, "_stop_data"}, 32'(dataOut), 32'(exp_data));
  endtask

  // Frame sent while halted: nothing may react.
  task automatic send_ignored(input string tag, input logic [7:0] w);
    int p0;
    p0 = pulses;
    en_cycle(1'b0);
    for (int i = 7; i >= 0; i--) begin
      en_cycle(w[i]);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_cnt2"}, 32'(cnt2), 32'd0);
    end
    en_cycle(1'b1);
    check({tag, "_data"}, 32'(dataOut), 32'(exp_data));
    check({tag, "_no_pulse"}, 32'(pulses), 32'(p0));
  endtask

  initial begin
    logic [7:0] words [4];
    logic [7:0] w;
    int gap;

    // 1. reset and idle line
    rst = 1'b1;
    #1;
    check("async_rst_data", 32'(dataOut), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) en_cycle(1'b1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_cnt2", 32'(cnt2), 32'd0);
    check("idle_data", 32'(dataOut), 32'd0);

    // 2. single word
    send_word("a5", 8'hA5, -1, -1);

    // 3. back-to-back words, downstream co2 model
    do_reset();
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF; words[3] = 8'h00;
    for (int n = 0; n < 4; n++) begin
      send_word($sformatf("b2b%0d", n), words[n], -1, -1);
      check($sformatf("co2_model%0d", n), 32'(pulses >= CO2_TARGET), 32'(n == 3));
    end

    // 4. co2In raised mid-word: word completes, then halt
    send_word("co2", 8'h3C, 4, -1);
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_cnt2", 32'(cnt2), 32'd0);
    send_ignored("halted", 8'h55);

    // 5. reset mid-word
    do_reset();
    en_cycle(1'b0);
    for (int i = 7; i >= 4; i--) en_cycle(1'b1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(dataOut), 32'd0);
    check("mid_rst_cnt2", 32'(cnt2), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_data = 8'h00;
    pulses = 0;
    en_cycle(1'b1);
    send_word("5a", 8'h5A, -1, -1);

    // 6. enable stall mid-word
    send_word("stall", 8'hC3, -1, 3);

    // randomized words, gaps and stalls
    for (int n = 0; n < 8; n++) begin
      w = 8'($urandom);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) en_cycle(1'b1);
      send_word($sformatf("rnd%0d", n), w, -1,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
